// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
//
// Producer side of the SHA-256 round datapath. The module takes one padded
// 512-bit block and expands it into the 64-word message schedule W[0..63].
// It presents one word per round, together with the round constant K[t] and
// the round index t.
//
// A 16-word sliding window holds W[t..t+15]. The word shown on w_out is always
// window slot 0, so the output is registered and has no combinational path
// from blk_data. When the window advances, it shifts down by one slot and the
// newly computed word enters slot 15. That word is therefore computed 16
// rounds before it is presented.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   blk_valid  in   1    blk_data holds a padded block
//   blk_ready  out  1    block accepted on blk_valid && blk_ready
//   blk_data   in   512  W[0] in bits 511:480 ... W[15] in bits 31:0
//   w_valid    out  1    w_out / k_out / round are valid
//   w_ready    in   1    consumer takes the current word
//   w_out      out  32   W[round]
//   k_out      out  32   K[round]
//   round      out  7    round index 0..63
//   last       out  1    w_valid && round == 63
//   busy       out  1    a block is being expanded
//
// Build option:
//   SHA256_SCHED_BACKPRESSURE_EN - when defined, the schedule advances only
//   while w_ready is high. When undefined, w_ready is ignored and the
//   schedule advances on every RUN cycle.
// -----------------------------------------------------------------------------
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [31:0]  k_out,
  output logic [6:0]   round,
  output logic         last,
  output logic         busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] f_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] f_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t      r_state;
  logic [5:0]  r_round;   // never exceeds 63, so 6 bits suffice internally
  logic [31:0] r_win [16];

  logic        w_accept;
  logic        w_adv;
  logic [31:0] w_new;
  logic [31:0] w_win_next [16];

  assign w_accept = (r_state == S_IDLE) && blk_valid;

`ifdef SHA256_SCHED_BACKPRESSURE_EN
  assign w_adv = (r_state == S_RUN) && w_ready;
`else
  // w_ready is kept as a port but has no influence: the schedule free-runs.
  assign w_adv = (r_state == S_RUN) && (w_ready | 1'b1);
`endif

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], mod 2^32
  assign w_new = f_sigma1(r_win[14]) + r_win[9] + f_sigma0(r_win[1]) + r_win[0];

  // One window slot per generate iteration: load from block, shift, or hold.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      always_comb begin
        w_win_next[gi] = r_win[gi];
        if (w_accept) begin
          w_win_next[gi] = blk_data[511 - 32*gi -: 32];
        end else if (w_adv) begin
          if (gi < 15) begin
            w_win_next[gi] = r_win[(gi < 15) ? gi + 1 : gi];
          end else begin
            w_win_next[gi] = w_new;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_win[gi] <= 32'h0;
        end else begin
          r_win[gi] <= w_win_next[gi];
        end
      end
    end
  endgenerate

  // Control FSM: all handshake outputs decode directly from r_state, so a
  // reset drops w_valid/busy without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_round <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (blk_valid) begin
            r_state <= S_RUN;
            r_round <= 6'd0;
          end
        end
        S_RUN: begin
          if (w_adv) begin
            if (r_round == 6'd63) begin
              r_state <= S_IDLE;
              r_round <= 6'd0;
            end else begin
              r_round <= r_round + 6'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_round <= 6'd0;
        end
      endcase
    end
  end

  assign blk_ready = (r_state == S_IDLE);
  assign w_valid   = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign round     = {1'b0, r_round};
  assign last      = (r_state == S_RUN) && (r_round == 6'd63);
  assign w_out     = r_win[0];
  assign k_out     = K_TABLE[r_round];

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// tb_sha256_msg_schedule
//
// Scoreboard bench for sha256_msg_schedule. Each block sent pushes its 64
// expected (W, K, t) entries, which come from a straightforward array-based
// SHA-256 schedule computation. A separate monitor compares every presented
// word against the head of the queue, and also checks acceptance latency and
// the number of valid cycles per block. Directed sequences cover reset, the
// NIST "abc" block, stall/no-stall behaviour, and block handshaking.
// -----------------------------------------------------------------------------
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [31:0]  k_out;
  logic [6:0]   round;
  logic         last;
  logic         busy;

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .k_out     (k_out),
    .round     (round),
    .last      (last),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 0;   // 1: w_ready randomized by the driver process

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_block(input logic [511:0] b);
    logic [31:0] wm [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wm[t] = b[511 - 32*t -: 32];
      else        wm[t] = ref_s1(wm[t-2]) + wm[t-7] + ref_s0(wm[t-15]) + wm[t-16];
      e.w = wm[t];
      e.k = KREF[t];
      e.t = t;
      q.push_back(e);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // ---------------- w_ready driver (random mode) ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode == 1) w_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit in_blk  = 0;
  bit hs_pend = 0;
  int vcnt    = 0;
  int stl     = 0;

  initial begin
    exp_t e;
    bit   adv;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_blk  = 0;
        hs_pend = 0;
        continue;
      end
      if (hs_pend) begin
        chk("accept_latency_valid", {31'b0, w_valid}, 32'd1);
        chk("accept_latency_round", {25'b0, round}, 32'd0);
        in_blk = 1;
        vcnt   = 0;
        stl    = 0;
      end
      if (w_valid) begin
        if (!in_blk) begin
          chk("valid_outside_block", {31'b0, w_valid}, 32'd0);
        end else if (q.size() == 0) begin
          chk("scoreboard_underflow", 32'(q.size()), 32'd1);
        end else begin
          e = q[0];
          vcnt++;
          chk($sformatf("w_out[%0d]", e.t), w_out, e.w);
          chk($sformatf("k_out[%0d]", e.t), k_out, e.k);
          chk($sformatf("round[%0d]", e.t), {25'b0, round}, e.t);
          chk($sformatf("last[%0d]", e.t), {31'b0, last}, {31'b0, (e.t == 63)});
`ifdef SHA256_SCHED_BACKPRESSURE_EN
          adv = w_ready;
`else
          adv = 1'b1;
`endif
          if (adv) begin
            void'(q.pop_front());
            if (e.t == 63) begin
              chk("valid_cycles", vcnt, 64 + stl);
              in_blk = 0;
            end
          end else begin
            stl++;
          end
        end
      end
      hs_pend = blk_valid && blk_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_ready(input string name);
    int n = 0;
    while (!blk_ready) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        chk(name, {31'b0, blk_ready}, 32'd1);
        return;
      end
    end
  endtask

  task automatic wait_round(input int r, input string name);
    int n = 0;
    while (!(w_valid && round == r)) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        chk(name, {25'b0, round}, r);
        return;
      end
    end
  endtask

  task automatic wait_last(input string name);
    int n = 0;
    while (!(w_valid && last)) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        chk(name, {31'b0, last}, 32'd1);
        return;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(blk_ready && q.size() == 0)) begin
      @(posedge clk); #1;
      n++;
      if (n > 2000) begin
        chk(name, 32'(q.size()), 32'd0);
        return;
      end
    end
  endtask

  // Sends one block; returns at posedge+1 right after the accepting edge.
  task automatic send_block(input logic [511:0] b);
    wait_ready("send_wait_ready");
    push_block(b);
    blk_data  = b;
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  logic [511:0] abc;
  logic [511:0] blk_a;
  logic [511:0] blk_b;

  initial begin
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    blk_data  = '0;
    w_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_ready", {31'b0, blk_ready}, 32'd1);
    chk("rst_w_valid",   {31'b0, w_valid},   32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    chk("rst_last",      {31'b0, last},      32'd0);
    chk("rst_round",     {25'b0, round},     32'd0);
    chk("rst_w_out",     w_out,              32'h00000000);
    chk("rst_k_out",     k_out,              32'h428a2f98);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NIST "abc" block
    abc = {32'h61626380, 448'h0, 32'h00000018};
    send_block(abc);
    chk("abc_w0",        w_out,              32'h61626380);
    chk("abc_k0",        k_out,              32'h428a2f98);
    chk("abc_busy",      {31'b0, busy},      32'd1);
    chk("abc_blk_ready", {31'b0, blk_ready}, 32'd0);
    wait_round(16, "abc_wait16");
    chk("abc_w16", w_out, 32'h61626380);
    @(posedge clk); #1;
    chk("abc_round17", {25'b0, round}, 32'd17);
    chk("abc_w17", w_out, 32'h000f0000);
    wait_last("abc_wait_last");
    chk("abc_k63",    k_out,          32'hc67178f2);
    chk("abc_round63", {25'b0, round}, 32'd63);
    @(posedge clk); #1;
    chk("abc_ready_after_last", {31'b0, blk_ready}, 32'd1);
    chk("abc_valid_after_last", {31'b0, w_valid},   32'd0);

    // Reset asserted mid-block at round 20
    send_block(rand_blk());
    wait_round(20, "rst_wait20");
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_w_valid",   {31'b0, w_valid},   32'd0);
    chk("midrst_blk_ready", {31'b0, blk_ready}, 32'd1);
    chk("midrst_round",     {25'b0, round},     32'd0);
    chk("midrst_busy",      {31'b0, busy},      32'd0);
    chk("midrst_w_out",     w_out,              32'h00000000);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(rand_blk());
    chk("post_rst_round", {25'b0, round}, 32'd0);
    wait_drain("post_rst_drain");

    // Drop w_ready for 5 cycles at round 30
    send_block(rand_blk());
    wait_round(30, "stall_wait30");
    w_ready = 1'b0;
`ifdef SHA256_SCHED_BACKPRESSURE_EN
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_round_held", {25'b0, round}, 32'd30);
    end
    w_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_resume_round", {25'b0, round}, 32'd31);
`else
    @(posedge clk); #1;
    chk("nobp_round_advances", {25'b0, round}, 32'd31);
    repeat (4) @(posedge clk);
    #1;
    w_ready = 1'b1;
`endif
    wait_drain("stall_drain");

    // Random blocks with randomized w_ready
    ready_mode = 1;
    repeat (6) send_block(rand_blk());
    wait_drain("random_drain");
    ready_mode = 0;
    w_ready    = 1'b1;
    @(posedge clk); #1;

    // blk_valid held across two blocks; blk_data changes during RUN
    blk_a = rand_blk();
    blk_b = rand_blk();
    push_block(blk_a);
    push_block(blk_b);
    blk_data  = blk_a;
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_data = blk_b;
    wait_last("hs_wait_last");
    @(posedge clk); #1;
    chk("hs_idle_w_valid",   {31'b0, w_valid},   32'd0);
    chk("hs_idle_blk_ready", {31'b0, blk_ready}, 32'd1);
    @(posedge clk); #1;
    chk("hs_b_w_valid", {31'b0, w_valid}, 32'd1);
    chk("hs_b_round",   {25'b0, round},   32'd0);
    chk("hs_b_w0",      w_out,            blk_b[511:480]);
    blk_valid = 1'b0;
    blk_data  = rand_blk();
    wait_drain("hs_drain");

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
